// File: rtl/octal_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters and the round-robin arbiter.
// The arbiter binds to the slave modport and the requester side to master.
interface octal_rr_arbiter_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );
endinterface

// File: rtl/octal_rr_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot and binary grant outputs.
// Define OCT_ARB_WATCHDOG_EN to build the hold watchdog that revokes grants after MAX_HOLD cycles.
module octal_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input logic               clk,
   input logic               rst_n,
   octal_rr_arbiter_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e     state_q;
   logic [2:0] ptr_q;
   logic [2:0] idx_q;
   logic [7:0] gnt_q;
   logic       valid_q;
   logic       timeout_q;

   logic [2:0] win_idx;
   logic [2:0] cand;
   logic       win_found;
   logic       expire;
   logic       release_now;

   // First set request at or after ptr_q, wrapping modulo 8.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      cand      = 3'd0;
      for (int i = 0; i < 8; i++) begin
         cand = ptr_q + 3'(i);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

`ifdef OCT_ARB_WATCHDOG_EN
   localparam int unsigned CntW = $clog2(MAX_HOLD);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   assign cnt_d  = (state_q == StGrant) ? cnt_q + CntW'(1) : '0;
   assign expire = (state_q == StGrant) && (cnt_q == CntW'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_max_hold;
   assign unused_max_hold = ^MAX_HOLD;
   assign expire          = 1'b0;
`endif

   assign release_now = bus.done || !bus.req[idx_q] || expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= 3'd0;
         idx_q     <= 3'd0;
         gnt_q     <= 8'h00;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (win_found) begin
                  state_q <= StGrant;
                  gnt_q   <= 8'd1 << win_idx;
                  idx_q   <= win_idx;
                  valid_q <= 1'b1;
                  ptr_q   <= win_idx + 3'd1;
               end
            end
            StGrant: begin
               if (release_now) begin
                  state_q   <= StIdle;
                  gnt_q     <= 8'h00;
                  idx_q     <= 3'd0;
                  valid_q   <= 1'b0;
                  // A done arriving on the expiry cycle is an ordinary release.
                  timeout_q <= expire && !bus.done;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = valid_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: doc/octal_rr_arbiter.md
# octal_rr_arbiter

Eight-way round-robin arbiter that shares a single downstream resource between eight requesters. It is the sequencing front-end for the octal-to-binary encoding datapath. The arbiter picks one requester at a time and holds a one-hot grant until that requester finishes. It also presents the 3-bit binary index of the winner, which is the encoding of the one-hot grant. An optional watchdog revokes grants that are held too long.

## Interface
- MAX_HOLD, 16: maximum cycles a grant may be held before watchdog revocation; legal range 2..256; used only when the watchdog is compiled in.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  8  request lines; req[i] stays high while requester i wants or owns the resource.
- done  input  1  single-cycle pulse from the current owner: transfer complete, release the grant.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- gnt_idx  output  3  binary index of the set gnt bit (gnt[k]=1 -> gnt_idx=k); 0 when idle.
- gnt_valid  output  1  high exactly while gnt is non-zero.
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant; constant 0 when the watchdog is compiled out.

## Operation
- State machine with two states:
  - IDLE: no grant.
  - GRANT: one owner holds the resource.
- Internal round-robin pointer ptr[2:0] gives the search start index.
- IDLE -> GRANT when |req=1:
  - Winner is the first set req bit searching ptr, ptr+1, …, ptr+7, modulo 8.
  - gnt, gnt_idx and gnt_valid are loaded at that edge.
  - ptr becomes (winner+1) mod 8 at the same edge.
- GRANT -> IDLE on any of these conditions, sampled at the clock edge:
  - (a) done=1.
  - (b) req[gnt_idx]=0: the owner abandoned its request.
  - (c) watchdog expiry.
- On GRANT -> IDLE, gnt, gnt_idx and gnt_valid clear to 0.
- In GRANT, changes on req lines other than the owner's are ignored.
- done is ignored while in IDLE.
- Wrap-around: ptr=7 with winner 7 gives ptr=0. Winner search wraps past 7 to 0.
- A requester that is still asserting after release is rescheduled by normal round-robin. It cannot win again while other requesters are pending.
- Reset values:
  - State IDLE, ptr=0.
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Watchdog counter=0.

## Timing
- Request-to-grant latency: 1 cycle. req sampled high at edge N gives gnt valid after edge N.
- Release-to-regrant gap: exactly 1 idle cycle. done sampled at edge N clears gnt at edge N. A new grant loads at edge N+1 if any req is high at that edge.
- Grant outputs come straight from flops, with no combinational path from req or done.
- Simultaneous events in the same cycle:
  - done and watchdog expiry together: done wins and timeout stays 0.
  - done and owner req drop together: one ordinary release.
- Reset asserted mid-grant clears all outputs immediately, without waiting for clk. The first grant after rst_n deasserts searches from index 0.

## Configuration
- Macro OCT_ARB_WATCHDOG_EN.
- Defined:
  - A hold counter of width clog2(MAX_HOLD) clears on entry to GRANT and increments each cycle in GRANT.
  - The owner holds the grant for at most MAX_HOLD cycles. If done has not arrived when the counter reaches MAX_HOLD-1, the grant is revoked at the next edge and timeout pulses high for that one cycle.
  - ptr is unaffected beyond its normal advance at grant time.
- Not defined:
  - No counter is built and timeout is tied to 0.
  - A grant is held indefinitely until done or the owner drops req.

## Test plan
- Reset then single request: req=8'h20 -> after 1 edge gnt=8'h20, gnt_idx=5, gnt_valid=1. Pulse done -> gnt=0 at that edge.
- Round-robin fairness: req=8'hFF held, done pulsed once per grant -> gnt_idx sequence 0,1,2,…,7,0 with one idle cycle between grants.
- Wrap and skip: ptr=6 (after granting 5), req=8'h03 -> next grant idx 0, then idx 1.
- Abandon: grant idx 3, drop req[3] with no done -> gnt clears at that edge and timeout stays 0.
- Asynchronous reset mid-grant: assert rst_n=0 between clock edges while gnt=8'h10 -> gnt=0 and gnt_valid=0 immediately. After release, req=8'hFF grants idx 0.
- Watchdog (OCT_ARB_WATCHDOG_EN, MAX_HOLD=4): hold req[2] with no done -> gnt held 4 cycles, then cleared with a 1-cycle timeout pulse. Repeat with done arriving in the 4th cycle -> no timeout pulse.
